// File: rtl/gray_code_receiver.sv
// Receiver for a 3-bit Gray-coded count link: decodes each valid code to binary,
// checks for single forward steps, locks after a run of good steps and counts step errors.
module gray_code_receiver #(
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [2:0]           gray_in,
  input  logic                 err_clr,
  output logic [2:0]           bin_out,
  output logic                 out_valid,
  output logic                 locked,
  output logic                 wrap,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t     state;
  logic [2:0] prev;
  logic [3:0] good;

  logic [2:0] bin_s;
  logic [2:0] step;
  logic [3:0] good_inc;
  logic       fwd;
  logic       hold;
  logic       bad_locked;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Step distance uses 3-bit wrap arithmetic, so 7 -> 0 is a forward step.
  always_comb begin
    bin_s      = gray2bin(gray_in);
    step       = bin_s - prev;
    fwd        = (step == 3'd1);
    hold       = (step == 3'd0);
    good_inc   = good + 4'd1;
    bad_locked = in_valid && (state == LOCKED) && !fwd && !hold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= 3'd0;
      good      <= 4'd0;
      bin_out   <= 3'd0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      out_valid <= in_valid;
      wrap      <= 1'b0;
      err       <= 1'b0;
      if (in_valid) begin
        bin_out <= bin_s;
        prev    <= bin_s;
        case (state)
          IDLE: begin
            good   <= 4'd0;
            state  <= ACQUIRE;
            locked <= 1'b0;
          end
          ACQUIRE: begin
            if (fwd) begin
              good <= good_inc;
              if (good_inc == LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (!hold) begin
              good <= 4'd0;
            end
          end
          LOCKED: begin
            if (fwd) begin
              wrap <= (prev == 3'd7) && (bin_s == 3'd0);
            end else if (!hold) begin
              err    <= 1'b1;
              good   <= 4'd0;
              state  <= ACQUIRE;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      // A clear in the same cycle as a locked error leaves the count at zero.
      if (err_clr)
        err_count <= '0;
      else if (bad_locked)
        err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_gray_code_receiver.sv
// Self-checking bench for gray_code_receiver: directed scenarios plus randomized
// traffic checked against a table-driven behavioural model.
module tb_gray_code_receiver;

  localparam int LOCK_COUNT = 2;
  localparam int ERR_CNT_W  = 2;
  localparam int CNT_MAX    = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [2:0]           gray_in = 3'd0;
  logic                 err_clr = 1'b0;
  logic [2:0]           bin_out;
  logic                 out_valid;
  logic                 locked;
  logic                 wrap;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;

  gray_code_receiver #(
    .LOCK_COUNT(LOCK_COUNT),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .gray_in  (gray_in),
    .err_clr  (err_clr),
    .bin_out  (bin_out),
    .out_valid(out_valid),
    .locked   (locked),
    .wrap     (wrap),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Gray code of each value 0..7.
  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  // Behavioural model: mode 0 = waiting for first sample, 1 = acquiring, 2 = locked.
  int m_mode, m_prev, m_good, m_cnt;
  logic [2:0]           e_bin;
  logic                 e_ov, e_locked, e_wrap, e_err;
  logic [ERR_CNT_W-1:0] e_cnt;

  function automatic int g2b(input logic [2:0] g);
    for (int i = 0; i < 8; i++)
      if (gtab[i] == g) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_good = 0; m_cnt = 0;
    e_bin = 3'd0; e_ov = 1'b0; e_locked = 1'b0; e_wrap = 1'b0; e_err = 1'b0; e_cnt = '0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] g, input logic c);
    int b, d;
    e_ov = v; e_wrap = 1'b0; e_err = 1'b0;
    if (v) begin
      b = g2b(g);
      d = (b - m_prev + 8) % 8;
      e_bin = 3'(b);
      if (m_mode == 0) begin
        m_good = 0;
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == 1) begin
          m_good++;
          if (m_good == LOCK_COUNT) m_mode = 2;
        end else if (d != 0) begin
          m_good = 0;
        end
      end else begin
        if (d == 1) begin
          e_wrap = (m_prev == 7 && b == 0);
        end else if (d != 0) begin
          e_err = 1'b1;
          m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
          m_good = 0;
          m_mode = 1;
        end
      end
      m_prev = b;
    end
    if (c) m_cnt = 0;
    e_locked = (m_mode == 2);
    e_cnt = ERR_CNT_W'(m_cnt);
  endtask

  // Present one cycle of stimulus, advance the model, and return #1 after the edge.
  task automatic drive(input logic v, input logic [2:0] g, input logic c);
    in_valid = v; gray_in = g; err_clr = c;
    @(posedge clk);
    model_step(v, g, c);
    #1;
    in_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_cmp++; if (bin_out !== 3'd0)     begin n_bad++; $display("FAIL reset_bin_out got %0d want 0", bin_out); end
    n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (locked !== 1'b0)      begin n_bad++; $display("FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if (wrap !== 1'b0)        begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
    n_cmp++; if (err !== 1'b0)         begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (err_count !== '0)     begin n_bad++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lockup();
    logic [2:0] want_bin [3] = '{3'd0, 3'd1, 3'd2};
    logic       want_lk  [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, gtab[i], 1'b0);
      n_cmp++; if (bin_out !== want_bin[i]) begin n_bad++; $display("FAIL lockup_bin_out[%0d] got %0d want %0d", i, bin_out, want_bin[i]); end
      n_cmp++; if (locked !== want_lk[i])   begin n_bad++; $display("FAIL lockup_locked[%0d] got %b want %b", i, locked, want_lk[i]); end
      n_cmp++; if (err !== 1'b0)            begin n_bad++; $display("FAIL lockup_err[%0d] got %b want 0", i, err); end
      n_cmp++; if (out_valid !== 1'b1)      begin n_bad++; $display("FAIL lockup_out_valid[%0d] got %b want 1", i, out_valid); end
    end
  endtask

  task automatic test_wrap();
    for (int v = 3; v <= 6; v++) drive(1'b1, gtab[v], 1'b0);
    drive(1'b1, 3'b100, 1'b0);
    n_cmp++; if (bin_out !== 3'd7) begin n_bad++; $display("FAIL wrap_bin7 got %0d want 7", bin_out); end
    n_cmp++; if (wrap !== 1'b0)    begin n_bad++; $display("FAIL wrap_at7 got %b want 0", wrap); end
    drive(1'b1, 3'b000, 1'b0);
    n_cmp++; if (bin_out !== 3'd0) begin n_bad++; $display("FAIL wrap_bin0 got %0d want 0", bin_out); end
    n_cmp++; if (wrap !== 1'b1)    begin n_bad++; $display("FAIL wrap_pulse got %b want 1", wrap); end
    n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL wrap_err got %b want 0", err); end
    n_cmp++; if (locked !== 1'b1)  begin n_bad++; $display("FAIL wrap_locked got %b want 1", locked); end
    drive(1'b0, 3'b000, 1'b0);
    n_cmp++; if (wrap !== 1'b0)    begin n_bad++; $display("FAIL wrap_one_cycle got %b want 0", wrap); end
  endtask

  task automatic test_hold_gaps();
    for (int v = 1; v <= 3; v++) drive(1'b1, gtab[v], 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'b010, 1'b0);
      n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL hold_err[%0d] got %b want 0", i, err); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_out_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (bin_out !== 3'd3)  begin n_bad++; $display("FAIL hold_bin_out[%0d] got %0d want 3", i, bin_out); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b111, 1'b0);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gap_out_valid[%0d] got %b want 0", i, out_valid); end
      n_cmp++; if (locked !== 1'b1)    begin n_bad++; $display("FAIL gap_locked[%0d] got %b want 1", i, locked); end
      n_cmp++; if (bin_out !== 3'd3)   begin n_bad++; $display("FAIL gap_bin_out[%0d] got %0d want 3", i, bin_out); end
    end
    drive(1'b1, 3'b110, 1'b0);
    n_cmp++; if (bin_out !== 3'd4) begin n_bad++; $display("FAIL gap_resume_bin got %0d want 4", bin_out); end
    n_cmp++; if (locked !== 1'b1)  begin n_bad++; $display("FAIL gap_resume_locked got %b want 1", locked); end
    n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL gap_resume_err got %b want 0", err); end
  endtask

  task automatic test_bad_step();
    for (int v = 5; v <= 9; v++) drive(1'b1, gtab[v % 8], 1'b0);
    drive(1'b1, 3'b110, 1'b0);
    n_cmp++; if (err !== 1'b1)       begin n_bad++; $display("FAIL bad_err got %b want 1", err); end
    n_cmp++; if (err_count !== 2'd1) begin n_bad++; $display("FAIL bad_err_count got %0d want 1", err_count); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL bad_locked got %b want 0", locked); end
    n_cmp++; if (bin_out !== 3'd4)   begin n_bad++; $display("FAIL bad_bin_out got %0d want 4", bin_out); end
    drive(1'b1, 3'b111, 1'b0);
    n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL relock_err got %b want 0", err); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL relock_mid got %b want 0", locked); end
    drive(1'b1, 3'b101, 1'b0);
    n_cmp++; if (bin_out !== 3'd6)   begin n_bad++; $display("FAIL relock_bin got %0d want 6", bin_out); end
    n_cmp++; if (locked !== 1'b1)    begin n_bad++; $display("FAIL relock_locked got %b want 1", locked); end
  endtask

  task automatic test_saturation();
    logic [ERR_CNT_W-1:0] want [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    int cur;
    do_reset();
    for (int v = 0; v <= 2; v++) drive(1'b1, gtab[v], 1'b0);
    cur = 2;
    for (int k = 0; k < 5; k++) begin
      cur = (cur + 4) % 8;
      drive(1'b1, gtab[cur], (k == 4));
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL sat_err[%0d] got %b want 1", k, err); end
      if (k < 4) begin
        n_cmp++; if (err_count !== want[k]) begin n_bad++; $display("FAIL sat_count[%0d] got %0d want %0d", k, err_count, want[k]); end
      end else begin
        n_cmp++; if (err_count !== '0) begin n_bad++; $display("FAIL clr_wins got %0d want 0", err_count); end
      end
      for (int s = 0; s < 2; s++) begin
        cur = (cur + 1) % 8;
        drive(1'b1, gtab[cur], 1'b0);
      end
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sat_relock[%0d] got %b want 1", k, locked); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, gtab[(g2b(gray_in) + 8) % 8], 1'b0);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL areset_pre_locked got %b want 1", locked); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (bin_out !== 3'd0)   begin n_bad++; $display("FAIL areset_bin got %0d want 0", bin_out); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL areset_locked got %b want 0", locked); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (err_count !== '0)   begin n_bad++; $display("FAIL areset_count got %0d want 0", err_count); end
    n_cmp++; if ({wrap, err} !== 2'b00) begin n_bad++; $display("FAIL areset_pulses got %b want 00", {wrap, err}); end
    #2 rst_n = 1'b1;
    drive(1'b1, 3'b101, 1'b0);
    n_cmp++; if (bin_out !== 3'd6)   begin n_bad++; $display("FAIL areset_first_bin got %0d want 6", bin_out); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL areset_first_locked got %b want 0", locked); end
    n_cmp++; if (err !== 1'b0)       begin n_bad++; $display("FAIL areset_first_err got %b want 0", err); end
  endtask

  task automatic test_random();
    logic v, c;
    logic [2:0] g;
    int r, nb;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 9);
      if (r < 6)      nb = (m_prev + 1) % 8;
      else if (r < 8) nb = m_prev;
      else            nb = $urandom_range(0, 7);
      g = gtab[nb];
      c = ($urandom_range(0, 24) == 0);
      drive(v, g, c);
      n_cmp++;
      if ({bin_out, out_valid, locked, wrap, err, err_count} !== {e_bin, e_ov, e_locked, e_wrap, e_err, e_cnt}) begin
        n_bad++;
        $display("FAIL random[%0d] got bin=%0d ov=%b lk=%b wr=%b er=%b cnt=%0d want bin=%0d ov=%b lk=%b wr=%b er=%b cnt=%0d",
                 i, bin_out, out_valid, locked, wrap, err, err_count, e_bin, e_ov, e_locked, e_wrap, e_err, e_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_wrap();
    test_hold_gaps();
    test_bad_step();
    test_saturation();
    test_async_reset();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_code_receiver.md
# gray_code_receiver

Receiving end of the 3-bit Gray-coded count link. It samples a Gray-coded count presented one code per valid cycle and converts it to binary. It checks that every new code is a legal single forward step, and it locks onto the stream after a run of good steps. While locked it flags wrap-around (7→0) and step errors, and it keeps a saturating error count for system status.

## Interface
- `LOCK_COUNT`, default 2: consecutive good forward steps needed to enter LOCKED (legal range 1–15).
- `ERR_CNT_W`, default 8: width of `err_count`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `gray_in` is valid this cycle.
- `gray_in` in 3: Gray-coded count (000, 001, 011, 010, 110, 111, 101, 100 = 0…7).
- `err_clr` in 1: synchronous clear of `err_count`.
- `bin_out` out 3: binary value of the last sampled code.
- `out_valid` out 1: one-cycle pulse; `bin_out` updated this cycle.
- `locked` out 1: FSM is in LOCKED.
- `wrap` out 1: one-cycle pulse, locked forward step 7→0.
- `err` out 1: one-cycle pulse, bad step while locked.
- `err_count` out `ERR_CNT_W`: saturating count of `err` pulses.

## Operation
**Decode**
- b2=g2, b1=g2^g1, b0=b1^g0.
- Applied on every `in_valid` sample, in every state.
- `prev` (3 bits) holds the last sampled binary value.

**Step classification**, with d = (b − prev) mod 8 (3-bit wrap arithmetic):
- d=1: FWD.
- d=0: HOLD (repeat; no progress, no error).
- any other value: BAD.

**FSM states**: IDLE, ACQUIRE, LOCKED. `good` is a 4-bit counter.
- IDLE: the first valid sample loads `prev` and `good`=0, then moves to ACQUIRE. No classification is made.
- ACQUIRE:
  - FWD: `good`+1. If `good`+1 == `LOCK_COUNT`, move to LOCKED.
  - HOLD: no change.
  - BAD: `good`=0, stay in ACQUIRE. No `err` and no count.
- LOCKED:
  - FWD: stay. Pulse `wrap` if prev=7 and b=0.
  - HOLD: stay.
  - BAD: pulse `err`, `err_count`+1 (saturating at all-ones), `good`=0, move to ACQUIRE.
- `prev` updates on every valid sample in every state. After a BAD step, re-acquisition therefore measures from the new code.
- With `in_valid`=0 there is no state change, and `out_valid`, `wrap` and `err` are 0.

**Error count**
- `err_clr` zeroes `err_count`.
- If `err_clr` arrives in the same cycle as a BAD-in-LOCKED event, clear wins: the count is 0, and `err` still pulses.

## Timing
- All outputs are registered.
- A sample at edge N shows `bin_out`, `out_valid`, `wrap`, `err` and the updated `err_count` during cycle N+1. `locked` reflects the FSM state after edge N.
- Latency is 1 cycle. Back-to-back valid samples are supported every cycle.
- Reset (asynchronous assert, take effect immediately):
  - state = IDLE;
  - `prev`, `good` = 0;
  - `bin_out` = 0, `out_valid` = 0, `locked` = 0, `wrap` = 0, `err` = 0, `err_count` = 0.
- Reset asserted mid-stream discards lock. After release, the first valid sample behaves as in IDLE.
- `locked` falls in the same cycle that `err` pulses.

## Test plan
- **Lock-up:** after reset, feed 000, 001, 011 on consecutive cycles. Required: `bin_out` = 0, 1, 2; `locked` rises in the cycle `bin_out`=2; `err`=0 throughout.
- **Wrap:** locked at value 6, feed 100 then 000. Required: `bin_out` = 7, then 0 with `wrap`=1 for exactly one cycle; no `err`.
- **Hold and gaps:** locked at value 3 (010), feed 010, 010, then idle `in_valid`=0 for 3 cycles, then 110. Required: no `err`; `out_valid` pulses only on valid cycles; `bin_out`=4; `locked` stays 1.
- **Bad step:** locked at value 1 (001), feed 110 (value 4). Required: `err`=1 for one cycle; `err_count`=1; `locked`=0. Then 111, 101 relock at `bin_out`=6.
- **Saturation and clear:**
  - With `ERR_CNT_W`=2, force 4 locked errors. Required: `err_count` = 1, 2, 3, 3.
  - Assert `err_clr` together with a 5th error. Required: `err_count`=0, `err`=1.
- **Async reset mid-lock:** assert `rst_n`=0 between edges. Required: all outputs 0 immediately. After release, the first sample 101 gives `bin_out`=6, `locked`=0, no `err`.
